// File: rtl/mem_store_buffer.sv
// Posted-store buffer: circular FIFO of word stores draining to the data RAM, with load forwarding.
// Latency: a captured store is visible on the RAM port and forwardable the cycle after capture.
// Backpressure: stall is high while full (stores refused); the head entry drains only when ramReady is high.
module mem_store_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     memWriteIn,
  input  logic                     memReadIn,
  input  logic [31:0]              addressIn,
  input  logic [DATA_W-1:0]        writeDataIn,
  output logic                     stall,
  output logic                     loadHit,
  output logic [DATA_W-1:0]        loadData,
  output logic                     ramWriteEnable,
  output logic [31:0]              ramAddress,
  output logic [DATA_W-1:0]        ramWriteData,
  input  logic                     ramReady,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [29:0]       addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     cnt;
  logic              full;
  logic              head_vld;
  logic              push;
  logic              pop;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign stall = full;
  assign count = cnt;

  // A write presented during reset is withdrawn so the RAM never commits a discarded entry.
  assign head_vld = !empty && !reset;
  // Full is judged on start-of-cycle occupancy; a same-cycle pop does not make room.
  assign push     = memWriteIn && !full;
  assign pop      = head_vld && ramReady;

  assign ramWriteEnable = head_vld;
  assign ramAddress     = head_vld ? {addr_mem[head], 2'b00} : 32'h0;
  assign ramWriteData   = head_vld ? data_mem[head] : '0;

  // Pointer and occupancy bookkeeping; push and pop may coincide.
  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // Entry storage; validity is derived from head/count, so the array needs no reset.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      addr_mem[tail] <= addressIn[31:2];
      data_mem[tail] <= writeDataIn;
    end
  end

  // Walk valid entries oldest to youngest so the youngest match overrides older ones.
  always_comb begin
    logic [PW-1:0] idx;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (k < int'(cnt) && addr_mem[idx] == addressIn[31:2]) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem[idx];
      end
    end
  end

  assign loadHit  = memReadIn && fwd_hit;
  assign loadData = loadHit ? fwd_data : '0;

endmodule

// File: tb/tb_mem_store_buffer.sv
module tb_mem_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        memWriteIn, memReadIn, ramReady;
  logic [31:0] addressIn, writeDataIn;
  logic        stall, loadHit, ramWriteEnable, empty;
  logic [31:0] loadData, ramAddress, ramWriteData;
  logic [2:0]  count;

  mem_store_buffer #(.DEPTH(DEPTH), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .memWriteIn(memWriteIn), .memReadIn(memReadIn),
    .addressIn(addressIn), .writeDataIn(writeDataIn), .stall(stall),
    .loadHit(loadHit), .loadData(loadData), .ramWriteEnable(ramWriteEnable),
    .ramAddress(ramAddress), .ramWriteData(ramWriteData), .ramReady(ramReady),
    .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [29:0] wa;
    logic [31:0] d;
  } ent_t;

  ent_t        model_q[$];
  logic [63:0] dut_log[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of stores, updated on each rising edge.
  always @(posedge clk) begin
    if (reset) begin
      model_q.delete();
    end else begin
      bit do_pop, do_push;
      do_pop  = (model_q.size() > 0) && ramReady;
      do_push = memWriteIn && (model_q.size() < DEPTH);
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back({addressIn[31:2], writeDataIn});
    end
  end

  // Compare every output against the model, and record what the RAM commits.
  always @(negedge clk) begin
    if (!reset) begin
      logic        e_hit;
      logic [31:0] e_ld;
      int          n;
      n     = model_q.size();
      e_hit = 1'b0;
      e_ld  = 32'h0;
      for (int i = 0; i < n; i++)
        if (model_q[i].wa == addressIn[31:2]) begin
          e_hit = 1'b1;
          e_ld  = model_q[i].d;
        end
      if (!memReadIn) begin
        e_hit = 1'b0;
        e_ld  = 32'h0;
      end
      chk("m_count", 64'(count), 64'(n));
      chk("m_empty", 64'(empty), 64'(n == 0));
      chk("m_stall", 64'(stall), 64'(n == DEPTH));
      chk("m_we",    64'(ramWriteEnable), 64'(n > 0));
      chk("m_raddr", 64'(ramAddress), (n > 0) ? 64'({model_q[0].wa, 2'b00}) : 64'h0);
      chk("m_rdata", 64'(ramWriteData), (n > 0) ? 64'(model_q[0].d) : 64'h0);
      chk("m_hit",   64'(loadHit), 64'(e_hit));
      chk("m_ldata", 64'(loadData), 64'(e_ld));
      if (ramWriteEnable && ramReady) dut_log.push_back({ramAddress, ramWriteData});
    end
  end

  task automatic drive(input logic w, input logic r, input logic [31:0] a,
                       input logic [31:0] d, input logic rdy);
    @(posedge clk);
    #1;
    memWriteIn  = w;
    memReadIn   = r;
    addressIn   = a;
    writeDataIn = d;
    ramReady    = rdy;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; memWriteIn = 1'b0; memReadIn = 1'b0;
    addressIn = 32'h0; writeDataIn = 32'h0; ramReady = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_we",    64'(ramWriteEnable), 64'd0);
    chk("rst_raddr", 64'(ramAddress), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);

    // Single store reaches RAM one cycle after capture, pops on the next edge
    drive(1, 0, 32'h100, 32'hA5A5A5A5, 0);
    drive(0, 0, 32'h0, 32'h0, 1);
    @(negedge clk);
    chk("t1_we",    64'(ramWriteEnable), 64'd1);
    chk("t1_raddr", 64'(ramAddress), 64'h100);
    chk("t1_rdata", 64'(ramWriteData), 64'hA5A5A5A5);
    drive(0, 0, 32'h0, 32'h0, 0);
    @(negedge clk);
    chk("t1_empty", 64'(empty), 64'd1);

    // Fill, hold a fifth store while full, release ramReady for one cycle
    for (int i = 0; i < 4; i++) drive(1, 0, 32'(i * 4), 32'h1000 + 32'(i), 0);
    drive(1, 0, 32'h10, 32'h55, 0);
    @(negedge clk);
    chk("t2_count_full", 64'(count), 64'd4);
    chk("t2_stall",      64'(stall), 64'd1);
    drive(1, 0, 32'h10, 32'h55, 0);
    drive(1, 0, 32'h10, 32'h55, 0);
    @(negedge clk);
    chk("t2_count_held", 64'(count), 64'd4);
    drive(1, 0, 32'h10, 32'h55, 1);
    drive(1, 0, 32'h10, 32'h55, 0);
    @(negedge clk);
    chk("t2_count_pop",  64'(count), 64'd3);
    chk("t2_stall_low",  64'(stall), 64'd0);
    drive(0, 0, 32'h0, 32'h0, 0);
    @(negedge clk);
    chk("t2_count_acc",  64'(count), 64'd4);
    chk("t2_head",       64'(ramAddress), 64'h4);
    repeat (4) drive(0, 0, 32'h0, 32'h0, 1);
    drive(0, 0, 32'h0, 32'h0, 0);
    @(negedge clk);
    chk("t2_drained", 64'(empty), 64'd1);
    chk("t2_last",    dut_log[dut_log.size() - 1], {32'h10, 32'h55});

    // Youngest-match forwarding, byte offset ignored
    drive(1, 0, 32'h20, 32'h11, 0);
    drive(1, 0, 32'h20, 32'h22, 0);
    drive(0, 1, 32'h22, 32'h0, 0);
    @(negedge clk);
    chk("t3_hit",   64'(loadHit), 64'd1);
    chk("t3_ldata", 64'(loadData), 64'h22);
    drive(0, 1, 32'h24, 32'h0, 0);
    @(negedge clk);
    chk("t3_miss",  64'(loadHit), 64'd0);
    chk("t3_mdata", 64'(loadData), 64'h0);
    drive(0, 0, 32'h0, 32'h0, 1);
    drive(0, 0, 32'h0, 32'h0, 1);
    drive(0, 0, 32'h0, 32'h0, 0);
    @(negedge clk);
    chk("t3_empty", 64'(empty), 64'd1);

    // Streaming at one store per cycle with two entries resident, pointers wrapping
    dut_log.delete();
    drive(1, 0, 32'h40, 32'hD0, 0);
    drive(1, 0, 32'h44, 32'hD1, 0);
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 32'h48 + 32'(4 * i), 32'hD2 + 32'(i), 1);
      @(negedge clk);
      chk("t4_count", 64'(count), 64'd2);
    end
    begin
      int budget;
      budget = 0;
      drive(0, 0, 32'h0, 32'h0, 1);
      @(negedge clk);
      chk("t4_count_end", 64'(count), 64'd2);
      while (!empty && budget < 12) begin
        drive(0, 0, 32'h0, 32'h0, 1);
        @(negedge clk);
        budget++;
      end
      chk("t4_drained", 64'(empty), 64'd1);
    end
    chk("t4_nwrites", 64'(dut_log.size()), 64'd10);
    for (int i = 0; i < 10; i++)
      if (i < dut_log.size())
        chk("t4_order", dut_log[i], {32'h40 + 32'(4 * i), 32'hD0 + 32'(i)});
    drive(0, 0, 32'h0, 32'h0, 0);

    // Reset mid-operation discards everything
    dut_log.delete();
    drive(1, 0, 32'h80, 32'hE0, 0);
    drive(1, 0, 32'h84, 32'hE1, 0);
    drive(1, 0, 32'h88, 32'hE2, 0);
    drive(0, 0, 32'h0, 32'h0, 0);
    @(negedge clk);
    chk("t5_count_pre", 64'(count), 64'd3);
    @(posedge clk);
    #1 reset = 1'b1; ramReady = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("t5_count", 64'(count), 64'd0);
    chk("t5_we",    64'(ramWriteEnable), 64'd0);
    repeat (3) drive(0, 0, 32'h0, 32'h0, 1);
    @(negedge clk);
    chk("t5_no_ram", 64'(dut_log.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
